// File: rtl/bullet_pixel_fetch.sv
// ----------------------------------------------------------------------------
// bullet_pixel_fetch : per-pixel bullet sprite lookup, 3-stage fixed latency
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bullet_pixel_fetch #(
  parameter int NUM_BULLETS = 4,
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 8
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                frame_start,
  input  logic                                pixel_valid,
  input  logic [9:0]                          DrawX,
  input  logic [9:0]                          DrawY,
  input  logic [NUM_BULLETS*10-1:0]           bullet_x,
  input  logic [NUM_BULLETS*10-1:0]           bullet_y,
  input  logic [NUM_BULLETS-1:0]              bullet_active,
  output logic [$clog2(SPR_W*SPR_H)-1:0]      rom_addr,
  input  logic [3:0]                          rom_data,
  output logic                                out_valid,
  output logic [3:0]                          index,
  output logic                                bullet_hit
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  logic [NUM_BULLETS*10-1:0] r_sx;
  logic [NUM_BULLETS*10-1:0] r_sy;
  logic [NUM_BULLETS-1:0]    r_sa;

  logic                      r_s1_valid;
  logic                      r_s1_hit;
  logic [XW-1:0]             r_offx;
  logic [YW-1:0]             r_offy;
  logic                      r_s2_valid;
  logic                      r_s2_hit;

  logic [NUM_BULLETS-1:0]    w_cover;
  logic                      w_any;
  logic [XW-1:0]             w_offx;
  logic [YW-1:0]             w_offy;

  // Bounds use 11-bit sums so sprites near the right/bottom edge never wrap.
  generate
    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
      logic [10:0] w_bx;
      logic [10:0] w_by;
      assign w_bx = {1'b0, r_sx[10*i +: 10]};
      assign w_by = {1'b0, r_sy[10*i +: 10]};
      assign w_cover[i] = r_sa[i]
                          && ({1'b0, DrawX} >= w_bx) && ({1'b0, DrawX} < w_bx + 11'(SPR_W))
                          && ({1'b0, DrawY} >= w_by) && ({1'b0, DrawY} < w_by + 11'(SPR_H));
    end
  endgenerate

  assign w_any = |w_cover;

  // Scan high to low so the lowest-numbered covering slot wins.
  always_comb begin
    w_offx = '0;
    w_offy = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (w_cover[i]) begin
        w_offx = DrawX[XW-1:0] - r_sx[10*i +: XW];
        w_offy = DrawY[YW-1:0] - r_sy[10*i +: YW];
      end
    end
  end

  assign rom_addr = r_s1_hit ? {r_offy, r_offx} : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sx       <= '0;
      r_sy       <= '0;
      r_sa       <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_offx     <= '0;
      r_offy     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_hit   <= 1'b0;
      out_valid  <= 1'b0;
      index      <= 4'd0;
      bullet_hit <= 1'b0;
    end else begin
      if (frame_start) begin
        r_sx <= bullet_x;
        r_sy <= bullet_y;
        r_sa <= bullet_active;
      end
      r_s1_valid <= pixel_valid;
      r_s1_hit   <= w_any;
      r_offx     <= w_offx;
      r_offy     <= w_offy;
      r_s2_valid <= r_s1_valid;
      r_s2_hit   <= r_s1_hit;
      out_valid  <= r_s2_valid;
      index      <= (r_s2_valid && r_s2_hit) ? rom_data : 4'd0;
      bullet_hit <= r_s2_valid && r_s2_hit && (rom_data != 4'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bullet_pixel_fetch.sv
// ----------------------------------------------------------------------------
// tb_bullet_pixel_fetch : directed table, corner sequences and random stream
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bullet_pixel_fetch;

  localparam int NB = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [9:0]    DrawX = '0;
  logic [9:0]    DrawY = '0;
  logic [39:0]   bx_bus = '0;
  logic [39:0]   by_bus = '0;
  logic [3:0]    act_bus = '0;
  logic [5:0]    rom_addr;
  logic [3:0]    rom_data = '0;
  logic          out_valid;
  logic [3:0]    index;
  logic          bullet_hit;

  bullet_pixel_fetch #(.NUM_BULLETS(NB), .SPR_W(8), .SPR_H(8)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .DrawX(DrawX), .DrawY(DrawY), .bullet_x(bx_bus), .bullet_y(by_bus),
    .bullet_active(act_bus), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .index(index), .bullet_hit(bullet_hit)
  );

  always #5 Clk = ~Clk;

  logic [3:0] rom [64];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model state: shadowed bullet list and queue of expected outputs
  int   m_bx [NB];
  int   m_by [NB];
  logic [3:0] m_act;
  typedef struct { logic v; logic [3:0] idx; logic h; } exp_t;
  exp_t q [$];

  function automatic void model(input int x, input int y, output logic hit, output int addr);
    hit = 1'b0;
    addr = 0;
    for (int i = 0; i < NB; i++) begin
      if (!hit && m_act[i] && m_bx[i] <= x && x < m_bx[i] + 8 && m_by[i] <= y && y < m_by[i] + 8) begin
        hit = 1'b1;
        addr = (y - m_by[i]) * 8 + (x - m_bx[i]);
      end
    end
  endfunction

  task automatic cycle(input logic fs, input logic pv, input int x, input int y);
    logic hit;
    int   addr;
    exp_t e;
    frame_start = fs;
    pixel_valid = pv;
    DrawX = 10'(x);
    DrawY = 10'(y);
    model(x, y, hit, addr);
    e.v = pv;
    e.idx = (pv && hit) ? rom[addr] : 4'd0;
    e.h = (e.idx != 4'd0);
    q.push_back(e);
    if (fs) begin
      for (int i = 0; i < NB; i++) begin
        m_bx[i] = int'(bx_bus[10*i +: 10]);
        m_by[i] = int'(by_bus[10*i +: 10]);
      end
      m_act = act_bus;
    end
    @(posedge Clk);
    #1;
    chk("rom_addr", int'(rom_addr), hit ? addr : 0);
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("out_valid", int'(out_valid), int'(e.v));
      chk("index", int'(index), int'(e.idx));
      chk("bullet_hit", int'(bullet_hit), int'(e.h));
    end else begin
      chk("out_valid_empty", int'(out_valid), 0);
      chk("index_empty", int'(index), 0);
      chk("bullet_hit_empty", int'(bullet_hit), 0);
    end
  endtask

  task automatic rst_pulse();
    Reset = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_index", int'(index), 0);
    chk("rst_bullet_hit", int'(bullet_hit), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    q.delete();
    m_act = '0;
    for (int i = 0; i < NB; i++) begin
      m_bx[i] = 0;
      m_by[i] = 0;
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  typedef struct {
    logic [3:0]  act;
    logic [39:0] bxb;
    logic [39:0] byb;
    logic        pv;
    int          x;
    int          y;
    int          e_addr;
    logic        e_v;
    logic [3:0]  e_idx;
    logic        e_h;
  } vec_t;

  vec_t vecs [11];

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = 4'(a ^ 4);
    m_act = '0;
    for (int i = 0; i < NB; i++) begin
      m_bx[i] = 0;
      m_by[i] = 0;
    end

    vecs[0]  = '{4'b0001, pk(100,0,0,0),  pk(100,0,0,0),  1'b1, 101, 101,  9, 1'b1, 4'hD, 1'b1};
    vecs[1]  = '{4'b0101, pk(50,0,48,0),  pk(50,0,48,0),  1'b1,  53,  52, 19, 1'b1, 4'h7, 1'b1};
    vecs[2]  = '{4'b0010, pk(0,1020,0,0), pk(0,470,0,0),  1'b1, 1023, 470, 3, 1'b1, 4'h7, 1'b1};
    vecs[3]  = '{4'b0010, pk(0,1020,0,0), pk(0,470,0,0),  1'b1,   0, 470,  0, 1'b1, 4'h0, 1'b0};
    vecs[4]  = '{4'b0010, pk(0,1020,0,0), pk(0,470,0,0),  1'b1, 1020, 478, 0, 1'b1, 4'h0, 1'b0};
    vecs[5]  = '{4'b0010, pk(0,1020,0,0), pk(0,470,0,0),  1'b1, 1019, 470, 0, 1'b1, 4'h0, 1'b0};
    vecs[6]  = '{4'b0001, pk(10,0,0,0),   pk(10,0,0,0),   1'b1,  14,  10,  4, 1'b1, 4'h0, 1'b0};
    vecs[7]  = '{4'b1000, pk(0,0,0,200),  pk(0,0,0,300),  1'b1, 207, 307, 63, 1'b1, 4'hB, 1'b1};
    vecs[8]  = '{4'b0000, pk(100,0,0,0),  pk(100,0,0,0),  1'b1, 101, 101,  0, 1'b1, 4'h0, 1'b0};
    vecs[9]  = '{4'b0001, pk(100,0,0,0),  pk(100,0,0,0),  1'b0, 101, 101,  9, 1'b0, 4'h0, 1'b0};
    vecs[10] = '{4'b0001, pk(100,0,0,0),  pk(100,0,0,0),  1'b1, 100, 107, 56, 1'b1, 4'hC, 1'b1};

    // Reset with live-looking bullet inputs but no frame_start: nothing hits
    act_bus = 4'b0001;
    bx_bus = pk(100, 0, 0, 0);
    by_bus = pk(100, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    Reset = 1'b0;
    cycle(1'b0, 1'b1, 100, 100);
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);
    chk("noframe_valid", int'(out_valid), 1);
    chk("noframe_index", int'(index), 0);
    chk("noframe_hit", int'(bullet_hit), 0);

    for (int v = 0; v < 11; v++) begin
      int a;
      act_bus = vecs[v].act;
      bx_bus = vecs[v].bxb;
      by_bus = vecs[v].byb;
      cycle(1'b1, 1'b0, 0, 0);
      cycle(1'b0, vecs[v].pv, vecs[v].x, vecs[v].y);
      a = int'(rom_addr);
      cycle(1'b0, 1'b0, 0, 0);
      cycle(1'b0, 1'b0, 0, 0);
      chk($sformatf("vec%0d_addr", v), a, vecs[v].e_addr);
      chk($sformatf("vec%0d_valid", v), int'(out_valid), int'(vecs[v].e_v));
      chk($sformatf("vec%0d_index", v), int'(index), int'(vecs[v].e_idx));
      chk($sformatf("vec%0d_hit", v), int'(bullet_hit), int'(vecs[v].e_h));
    end

    // frame_start on the same edge as a pixel: pixel sees the old position
    act_bus = 4'b0001;
    bx_bus = pk(100, 0, 0, 0);
    by_bus = pk(100, 0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    bx_bus = pk(200, 0, 0, 0);
    cycle(1'b1, 1'b1, 100, 100);
    cycle(1'b0, 1'b1, 100, 100);
    cycle(1'b0, 1'b0, 0, 0);
    chk("coinc_valid", int'(out_valid), 1);
    chk("coinc_index", int'(index), 4);
    chk("coinc_hit", int'(bullet_hit), 1);
    cycle(1'b0, 1'b0, 0, 0);
    chk("after_valid", int'(out_valid), 1);
    chk("after_index", int'(index), 0);
    chk("after_hit", int'(bullet_hit), 0);

    // Streaming with reset at pixel 8
    bx_bus = pk(100, 0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 100 + k, 100 + k % 3);
    pixel_valid = 1'b1;
    rst_pulse();
    for (int k = 9; k < 16; k++) cycle(k == 9, 1'b1, 100 + k % 8, 101);
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);

    // Random stream near the right screen edge
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < NB; i++) begin
          bx_bus[10*i +: 10] = 10'($urandom_range(980, 1023));
          by_bus[10*i +: 10] = 10'($urandom_range(0, 40));
        end
        act_bus = 4'($urandom_range(0, 15));
      end
      if (n == 250) begin
        pixel_valid = 1'b1;
        rst_pulse();
      end
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 4) != 0,
            int'($urandom_range(975, 1023)), int'($urandom_range(0, 50)));
    end
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
